// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: pipelined RV32/RV64 immediate extender with valid/ready and flush.
// Define IMM_ERR_CNT_EN to build the saturating illegal-op counter on err_cnt.
module imm_ext_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [15:0]      err_cnt
);

  typedef struct packed {
    logic             vld;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } stg_t;

  stg_t              r_stg [STAGES];
  stg_t              w_up  [STAGES];
  logic [STAGES-1:0] w_ld;
  logic [XLEN-1:0]   w_imm;
  logic              w_err;
  logic              w_s;
  logic              w_sh5;
  logic              w_unused;

  assign w_s      = inst[31];
  assign w_sh5    = (XLEN == 64) & inst[25];
  assign w_unused = ^inst[6:0];

  always_comb begin
    w_imm = '0;
    w_err = 1'b0;
    unique case (op)
      3'd0: w_imm = {{(XLEN-11){w_s}}, inst[30:20]};
      3'd1: w_imm = {{(XLEN-11){w_s}}, inst[30:25],
                     inst[11:7]};
      3'd2: w_imm = {{(XLEN-12){w_s}}, inst[7],
                     inst[30:25], inst[11:8], 1'b0};
      3'd3: w_imm = {{(XLEN-31){w_s}}, inst[30:12],
                     12'b0};
      3'd4: w_imm = {{(XLEN-20){w_s}}, inst[19:12],
                     inst[20], inst[30:21], 1'b0};
      3'd5: w_imm = {{(XLEN-6){1'b0}}, w_sh5,
                     inst[24:20]};
      3'd6: w_imm = {{(XLEN-5){1'b0}}, inst[19:15]};
      default: w_err = 1'b1;
    endcase
  end

  // A stage can load if any stage at or after it is empty, or the tail drains.
  always_comb begin
    logic acc;
    w_ld = '0;
    acc  = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc     = acc | ~r_stg[i].vld;
      w_ld[i] = acc;
    end
  end

  always_comb begin
    w_up[0] = '{vld: in_valid, imm: w_imm,
                tag: in_tag, err: w_err};
    for (int i = 1; i < STAGES; i++)
      w_up[i] = r_stg[i-1];
  end

  assign in_ready = !flush && w_ld[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++)
        r_stg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < STAGES; i++)
        r_stg[i].vld <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (w_ld[i]) begin
          if (w_up[i].vld) r_stg[i] <= w_up[i];
          else             r_stg[i].vld <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_stg[STAGES-1].vld;
  assign out_imm   = r_stg[STAGES-1].imm;
  assign out_tag   = r_stg[STAGES-1].tag;
  assign out_err   = r_stg[STAGES-1].err;

`ifdef IMM_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (out_valid && out_ready && out_err &&
             r_err_cnt != 16'hFFFF)
      r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: scoreboard bench driving an RV32/3-stage and an RV64/2-stage
// instance from shared stimulus, checked against an arithmetic reference model.
module tb_imm_ext_pipe;
  localparam int TW = 5;

  typedef struct {
    logic [63:0]   imm;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [31:0]   inst;
  logic [2:0]    op;
  logic [TW-1:0] in_tag;

  logic          a_in_ready, a_out_valid, a_out_err;
  logic [31:0]   a_out_imm;
  logic [TW-1:0] a_out_tag;
  logic [15:0]   a_err_cnt;
  logic          b_in_ready, b_out_valid, b_out_err;
  logic [63:0]   b_out_imm;
  logic [TW-1:0] b_out_tag;
  logic [15:0]   b_err_cnt;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .STAGES(3), .TAG_W(TW)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .inst(inst), .op(op), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_tag(a_out_tag),
    .out_err(a_out_err), .err_cnt(a_err_cnt));

  imm_ext_pipe #(.XLEN(64), .STAGES(2), .TAG_W(TW)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .inst(inst), .op(op), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_tag(b_out_tag),
    .out_err(b_out_err), .err_cnt(b_err_cnt));

  logic          ir [2];
  logic          ov [2];
  logic [63:0]   oimm [2];
  logic [TW-1:0] otag [2];
  logic          oerr [2];
  logic [15:0]   ocnt [2];

  assign ir[0]   = a_in_ready;
  assign ir[1]   = b_in_ready;
  assign ov[0]   = a_out_valid;
  assign ov[1]   = b_out_valid;
  assign oimm[0] = {32'h0, a_out_imm};
  assign oimm[1] = b_out_imm;
  assign otag[0] = a_out_tag;
  assign otag[1] = b_out_tag;
  assign oerr[0] = a_out_err;
  assign oerr[1] = b_out_err;
  assign ocnt[0] = a_err_cnt;
  assign ocnt[1] = b_err_cnt;

  exp_t          q [2][$];
  logic [63:0]   cur_exp [2];
  logic          cur_err;
  int            n_tests = 0;
  int            n_fail  = 0;
  int unsigned   ecnt [2];
  logic          stall [2];
  logic [63:0]   s_imm [2];
  logic [TW-1:0] s_tag [2];
  logic          s_err [2];
  logic          armed = 1'b0;

  task automatic chk(input string nm, input int d,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h",
               nm, d, act, exp);
    end
  endtask

  // Immediate value as signed arithmetic on the raw field, then truncated.
  function automatic logic [63:0] ref_imm(
      input logic [31:0] x, input logic [2:0] o,
      input int xlen);
    longint v;
    logic [63:0] r;
    v = 0;
    case (o)
      3'd0: begin
        v = x[31:20];
        if (x[31]) v -= 4096;
      end
      3'd1: begin
        v = {x[31:25], x[11:7]};
        if (x[31]) v -= 4096;
      end
      3'd2: begin
        v = {x[31], x[7], x[30:25], x[11:8]};
        v = v * 2;
        if (x[31]) v -= 8192;
      end
      3'd3: begin
        v = x[31:12];
        v = v * 4096;
        if (x[31]) v -= 64'h1_0000_0000;
      end
      3'd4: begin
        v = {x[31], x[19:12], x[20], x[30:21]};
        v = v * 2;
        if (x[31]) v -= 2097152;
      end
      3'd5: v = (xlen == 32) ? x[24:20] : x[25:20];
      3'd6: v = x[19:15];
      default: v = 0;
    endcase
    r = v;
    if (xlen == 32) r[63:32] = '0;
    return r;
  endfunction

  task automatic drive(input logic [31:0] i, input logic [2:0] o,
                       input logic [TW-1:0] t,
                       input logic [63:0] e32,
                       input logic [63:0] e64);
    inst       = i;
    op         = o;
    in_tag     = t;
    cur_exp[0] = e32;
    cur_exp[1] = e64;
    cur_err    = (o == 3'd7);
    in_valid   = 1'b1;
  endtask

  task automatic rnd_drive(input logic [TW-1:0] t);
    logic [31:0] i;
    logic [2:0]  o;
    i = $urandom;
    o = 3'($urandom_range(0, 7));
    drive(i, o, t, ref_imm(i, o, 32), ref_imm(i, o, 64));
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic lat_check(input logic [TW-1:0] t);
    idle(4);
    #1 rnd_drive(t);
    out_ready = 1'b1;
    @(negedge clk);
    chk("lat_accept", 0, 64'(ir[0]), 64'd1);
    chk("lat_accept", 1, 64'(ir[1]), 64'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("lat_valid", 0, 64'(ov[0]), 64'(k == 3));
      chk("lat_valid", 1, 64'(ov[1]), 64'(k == 2));
    end
  endtask

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        logic [63:0] ce;
`ifdef IMM_ERR_CNT_EN
        ce = 64'(ecnt[d]);
`else
        ce = 64'd0;
`endif
        chk("err_cnt", d, 64'(ocnt[d]), ce);
        if (stall[d] && ov[d]) begin
          chk("hold_imm", d, oimm[d], s_imm[d]);
          chk("hold_tag", d, 64'(otag[d]), 64'(s_tag[d]));
          chk("hold_err", d, 64'(oerr[d]), 64'(s_err[d]));
        end
        stall[d] = ov[d] && !out_ready;
        s_imm[d] = oimm[d];
        s_tag[d] = otag[d];
        s_err[d] = oerr[d];
        if (ov[d] && out_ready) begin
          if (q[d].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out dut%0d: got tag %h expected none",
                     d, otag[d]);
          end else begin
            e = q[d].pop_front();
            chk("out_imm", d, oimm[d], e.imm);
            chk("out_tag", d, 64'(otag[d]), 64'(e.tag));
            chk("out_err", d, 64'(oerr[d]), 64'(e.err));
            if (e.err && ecnt[d] < 65535) ecnt[d]++;
          end
        end
        if (!rst_n) begin
          q[d].delete();
          ecnt[d]  = 0;
          stall[d] = 1'b0;
        end else if (flush) begin
          q[d].delete();
        end else if (in_valid && ir[d]) begin
          q[d].push_back('{cur_exp[d], in_tag, cur_err});
        end
      end
    end
  end

  logic [31:0] d_inst [12] = '{
    32'hFFF00093, 32'hFE000E23, 32'h0080006F, 32'h123450B7,
    32'h01F09093, 32'h800000B7, 32'h03F09093, 32'h800F8073,
    32'hFE000FE3, 32'h12345678, 32'hFFFFFFFF, 32'h00000013};
  logic [2:0] d_op [12] = '{
    3'd0, 3'd1, 3'd4, 3'd3, 3'd5, 3'd3,
    3'd5, 3'd6, 3'd2, 3'd7, 3'd7, 3'd7};
  logic [63:0] d_e32 [12] = '{
    64'hFFFFFFFF, 64'hFFFFFFFC, 64'h8, 64'h12345000,
    64'h1F, 64'h80000000, 64'h1F, 64'h1F,
    64'hFFFFFFFE, 64'h0, 64'h0, 64'h0};
  logic [63:0] d_e64 [12] = '{
    64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'h8,
    64'h12345000, 64'h1F, 64'hFFFFFFFF_80000000,
    64'h3F, 64'h1F, 64'hFFFFFFFF_FFFFFFFE,
    64'h0, 64'h0, 64'h0};

  initial begin
    int wait_n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; inst = '0; op = '0; in_tag = '0;
    cur_exp[0] = '0; cur_exp[1] = '0; cur_err = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ecnt[d] = 0; stall[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    armed = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", d, 64'(ov[d]), 64'd0);
      chk("rst_ready", d, 64'(ir[d]), 64'd1);
      chk("rst_imm", d, oimm[d], 64'd0);
      chk("rst_tag", d, 64'(otag[d]), 64'd0);
    end

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(d_inst[i], d_op[i], TW'(i), d_e32[i], d_e64[i]);
    end
    lat_check(5'd20);

    // Fill with out_ready low: B is full after 2, A after 3.
    idle(4);
    #1 out_ready = 1'b0;
    rnd_drive(5'd0);
    @(negedge clk); chk("fill0", 0, 64'(ir[0]), 64'd1);
    @(posedge clk); #1 rnd_drive(5'd1);
    @(negedge clk); chk("fill1", 0, 64'(ir[0]), 64'd1);
    @(posedge clk); #1 rnd_drive(5'd2);
    @(negedge clk);
    chk("fill2", 0, 64'(ir[0]), 64'd1);
    chk("full", 1, 64'(ir[1]), 64'd0);
    @(posedge clk); #1 rnd_drive(5'd3);
    @(negedge clk);
    chk("full", 0, 64'(ir[0]), 64'd0);
    chk("full_valid", 0, 64'(ov[0]), 64'd1);
    chk("full_tag", 0, 64'(otag[0]), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("ready_chain", 0, 64'(ir[0]), 64'd1);
    @(posedge clk); #1 rnd_drive(5'd4);
    @(posedge clk); #1 rnd_drive(5'd5);

    idle(6);
    #1 rnd_drive(5'd6);
    @(posedge clk); #1 rnd_drive(5'd7);
    @(posedge clk); #1 rnd_drive(5'd8);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 0, 64'(ir[0]), 64'd0);
    chk("flush_ready", 1, 64'(ir[1]), 64'd0);
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("flush_valid", 0, 64'(ov[0]), 64'd0);
      chk("flush_valid", 1, 64'(ov[1]), 64'd0);
    end
    lat_check(5'd9);

    idle(4);
    #1 out_ready = 1'b0;
    rnd_drive(5'd10);
    @(posedge clk); #1 rnd_drive(5'd11);
    @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("mid_rst_valid", d, 64'(ov[d]), 64'd0);
      chk("mid_rst_cnt", d, 64'(ocnt[d]), 64'd0);
      chk("mid_rst_ready", d, 64'(ir[d]), 64'd1);
    end

    for (int k = 0; k < 1500; k++) begin
      @(posedge clk); #1;
      rnd_drive(TW'(k));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
    end

    @(posedge clk); #1;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    wait_n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("drain_left", d, 64'(q[d].size()), 64'd0);
      chk("drain_valid", d, 64'(ov[d]), 64'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate sign-extender in the decode stage.
- Takes the raw 32-bit instruction plus an immediate-format select, then produces an XLEN-wide immediate through STAGES register stages.
- Uses a valid/ready handshake, supports a flush, and carries a sideband tag.
- Sits between the fetch/decode register and the operand-select mux; supports RV32 and RV64.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- STAGES, 1, number of pipeline register stages, 1..4.
- TAG_W, 5, width of the sideband tag carried with each immediate (e.g. rd index or ROB id).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- flush  input  1  synchronous clear of all in-flight entries.
- in_valid  input  1  inst/op/tag are valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- inst  input  32  full instruction word; immediate bits are taken from inst[31:7].
- op  input  3  format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 shift-I, 6 CSR uimm, 7 illegal.
- in_tag  input  TAG_W  sideband data, passed through unchanged.
- out_valid  output  1  out_imm/out_tag/out_err are valid.
- out_ready  input  1  consumer accepts the output.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the output entry.
- out_err  output  1  entry had op=7.
- err_cnt  output  16  illegal-op count (see Optional Feature).

Behaviour:
- Reset: when rst_n=0 at a clock edge, all stage valid bits, out_imm, out_tag, out_err and err_cnt are cleared to 0. in_ready reads 1 from the cycle after reset. Reset mid-operation discards all entries.
- Extension (combinational, computed ahead of stage 0), with s = inst[31]:
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U: sext({inst[31:12], 12'b0}); for XLEN=64 bits 63:32 replicate s.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - shift-I: zero-extended shamt. XLEN=32 uses inst[24:20]; XLEN=64 uses inst[25:20]. No sign extension.
  - CSR uimm: zero-extended inst[19:15].
  - illegal: imm=0, err=1.
- Pipeline:
  - STAGES registers, each holding {valid, imm, tag, err}.
  - A stage loads when it is empty or its contents move downstream in the same cycle.
  - The last stage moves when out_ready=1.
  - in_ready = !flush && (stage0 empty || stage0 moves).
  - A transfer occurs on in_valid && in_ready.
  - Latency: exactly STAGES cycles from accepted input to out_valid with no stall.
  - Throughput: 1 per cycle while out_ready=1.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_imm/out_tag/out_err are held stable.
  - Entries are never dropped or duplicated.
  - in_valid may deassert without its value being accepted.
- Flush:
  - All valid bits clear at the edge.
  - in_ready=0 during the flush cycle, so an input offered in that cycle is not accepted; flush has priority.
  - out_valid=0 the following cycle.
  - Data registers may retain stale values.
- Full condition: all stages valid and out_ready=0 gives in_ready=0. When out_ready rises, in_ready rises in the same cycle (combinational ready chain).

Optional Feature:
- Macro IMM_ERR_CNT_EN.
- Defined:
  - err_cnt increments by 1 each time an entry with err=1 transfers out (out_valid && out_ready && out_err).
  - It saturates at 16'hFFFF.
  - Cleared by reset, not by flush.
- Undefined: err_cnt is tied to 16'h0 and the counter logic is absent.

Test Plan:
- XLEN=32, STAGES=1, out_ready=1: inst=0xFFF00093, op=0 -> out_imm=0xFFFFFFFF one cycle later. inst=0xFE000E23, op=1 -> 0xFFFFFFFC.
- inst=0x0080006F, op=4 -> 0x00000008. inst=0x123450B7, op=3 -> 0x12345000. inst=0x01F09093, op=5 -> 0x0000001F. With XLEN=64: inst=0x800000B7, op=3 -> 0xFFFFFFFF80000000.
- STAGES=3, back-to-back stream of 6 entries, tags 0..5, out_ready held 0 for 4 cycles mid-stream:
  - in_ready falls once 3 entries are held.
  - Outputs stay stable during the stall.
  - All 6 tags emerge in order with correct immediates; none lost or duplicated.
- STAGES=2, two entries in flight, flush=1 with in_valid=1 in the same cycle -> in_ready=0; out_valid=0 for the next 2 cycles; a later input emerges after exactly 2 cycles.
- Reset asserted mid-stream with 2 entries valid -> out_valid=0 and err_cnt=0 after the edge; in_ready=1 on the following cycle.
- IMM_ERR_CNT_EN defined: 3 op=7 inputs -> each shows out_err=1 and out_imm=0, err_cnt=3. Forced to 0xFFFE, then 3 more errors -> err_cnt stays 0xFFFF. Macro undefined -> err_cnt is always 0.
